// File: rtl/tone_scheduler.sv
// -----------------------------------------------------------------------------
// tone_scheduler
//
// Sequences notes for the sine LUT generator. Note requests (divider + duration)
// are queued in a small FIFO. For each note the scheduler restarts the sine phase,
// emits a phase-step strobe every `div` clock cycles for 256 * `dur` strobes, and
// then inserts a muted gap before the next note. A divider of 0 is a rest: it is
// timed with REST_DIV but emits no strobes and keeps the output muted. A duration
// of 0 skips the request and leaves only the gap.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   req_valid   note request valid
//   req_ready   queue can accept a request (not full, no flush)
//   req_div     clk cycles per phase step; 0 = rest
//   req_dur     note length in sine periods (256 strobes each); 0 = skip
//   flush       abort the current note and empty the queue
//   sin_clk     1-cycle phase-step strobe to the sine generator
//   sine_reset  1-cycle phase restart to the sine generator
//   mute        1 = output stage silenced
//   playing     scheduler is not idle
//   busy        playing or requests still queued
//   note_done   1-cycle pulse when a note, rest or skip completes
// -----------------------------------------------------------------------------
module tone_scheduler #(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DUR_W      = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 256,
    parameter int unsigned REST_DIV   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DIV_W-1:0] req_div,
    input  logic [DUR_W-1:0] req_dur,
    input  logic             flush,
    output logic             sin_clk,
    output logic             sine_reset,
    output logic             mute,
    output logic             playing,
    output logic             busy,
    output logic             note_done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DIV_W-1:0] REST_D   = DIV_W'(REST_DIV);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPlay,
        StGap
    } state_e;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_mem [FIFO_DEPTH];
    logic [DUR_W-1:0] dur_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign req_ready  = !fifo_full && !flush;
    assign push       = req_valid && req_ready && !reset;

    // Storage needs no reset; only the pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            div_mem[wr_ptr_q] <= req_div;
            dur_mem[wr_ptr_q] <= req_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= PTR_W'(wr_ptr_q + PTR_W'(1));
            end
            if (pop) begin
                rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
            end
            unique case ({push, pop})
                2'b10:   count_q <= CNT_W'(count_q + CNT_W'(1));
                2'b01:   count_q <= CNT_W'(count_q - CNT_W'(1));
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Note sequencer
    // ------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic [DIV_W-1:0] cur_div_q,  cur_div_d;
    logic [DUR_W-1:0] cur_dur_q,  cur_dur_d;
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic [DUR_W-1:0] per_cnt_q,  per_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;

    logic [DIV_W-1:0] eff_div;
    logic             tick;
    logic             strobe;
    logic             load_reset;
    logic             done;

    // Rests are timed exactly like notes, just with a fixed divider.
    assign eff_div = (cur_div_q == '0) ? REST_D : cur_div_q;
    assign tick    = (div_cnt_q == DIV_W'(eff_div - DIV_W'(1)));

    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        cur_dur_d  = cur_dur_q;
        div_cnt_d  = div_cnt_q;
        step_cnt_d = step_cnt_q;
        per_cnt_d  = per_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pop        = 1'b0;
        strobe     = 1'b0;
        load_reset = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    cur_div_d = div_mem[rd_ptr_q];
                    cur_dur_d = dur_mem[rd_ptr_q];
                    state_d   = StLoad;
                end
            end

            StLoad: begin
                if (cur_dur_q == '0) begin
                    // Skipped request: report completion without touching the phase.
                    done      = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end else begin
                    load_reset = 1'b1;
                    div_cnt_d  = '0;
                    step_cnt_d = '0;
                    per_cnt_d  = cur_dur_q;
                    state_d    = StPlay;
                end
            end

            StPlay: begin
                if (tick) begin
                    div_cnt_d  = '0;
                    step_cnt_d = 8'(step_cnt_q + 8'd1);
                    strobe     = (cur_div_q != '0);
                    // One sine period is 256 steps; the note ends on the last step
                    // of its last period.
                    if (step_cnt_q == 8'hff) begin
                        per_cnt_d = DUR_W'(per_cnt_q - DUR_W'(1));
                        if (per_cnt_q == DUR_W'(1)) begin
                            done      = 1'b1;
                            gap_cnt_d = '0;
                            state_d   = StGap;
                        end
                    end
                end else begin
                    div_cnt_d = DIV_W'(div_cnt_q + DIV_W'(1));
                end
            end

            StGap: begin
                if (gap_cnt_q == GAP_LAST) begin
                    // Chain straight into the next note without an idle cycle.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        cur_div_d = div_mem[rd_ptr_q];
                        cur_dur_d = dur_mem[rd_ptr_q];
                        state_d   = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gap_cnt_d = GAP_W'(gap_cnt_q + GAP_W'(1));
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q    <= StIdle;
            cur_div_q  <= '0;
            cur_dur_q  <= '0;
            div_cnt_q  <= '0;
            step_cnt_q <= '0;
            per_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            cur_dur_q  <= cur_dur_d;
            div_cnt_q  <= div_cnt_d;
            step_cnt_q <= step_cnt_d;
            per_cnt_q  <= per_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Reset forces the output values immediately; flush restarts the phase at
    // once and takes the sequencer idle on the next edge.
    assign sin_clk    = strobe && !reset;
    assign sine_reset = reset || flush || load_reset;
    assign mute       = reset || !((state_q == StPlay) && (cur_div_q != '0));
    assign playing    = !reset && (state_q != StIdle);
    assign busy       = !reset && ((state_q != StIdle) || !fifo_empty);
    assign note_done  = done && !reset && !flush;

endmodule
